// File: rtl/ruleid_capture.sv
// Rule-ID capture buffer: snoops a wide beat stream into on-chip memory and
// exposes control, counters and the captured beats on the status register bus.
module ruleid_capture #(
  parameter int                     DATA_W      = 512,
  parameter int                     DEPTH       = 512,
  parameter int                     STAT_AWIDTH = 4,
  parameter logic [STAT_AWIDTH-1:0] BLOCK_ID    = 4'hC,
  parameter bit                     ARM_ON_RST  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [29:0]       status_addr,
  input  logic              status_read,
  input  logic              status_write,
  input  logic [31:0]       status_writedata,
  output logic [31:0]       status_readdata,
  output logic              status_readdata_valid
);

  localparam int LANES  = DATA_W / 32;
  localparam int LANE_W = $clog2(LANES);
  localparam int LW     = (LANE_W > 0) ? LANE_W : 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  // Input snoop pipeline
  logic [DATA_W-1:0] s1_data_r;
  logic [DATA_W-1:0] s2_data_r;
  logic              s1_valid_r;
  logic              s2_valid_r;

  // Capture state
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] mem_q_r;
  logic              armed_r;
  logic              wrap_mode_r;
  logic              full_r;
  logic              wrapped_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [31:0]       captured_r;
  logic [31:0]       dropped_r;

  // Status bus request and response stages
  logic                   req_read_r;
  logic                   req_write_r;
  logic [STAT_AWIDTH-1:0] req_blk_r;
  logic [15:0]            req_addr_r;
  logic [2:0]             req_wdata_r;
  logic                   rsp_valid_r;
  logic                   rsp_mem_r;
  logic                   rsp_in_range_r;
  logic [LW-1:0]          rsp_lane_r;
  logic [31:0]            rsp_reg_r;

  logic          hit_s;
  logic          rd_s;
  logic          ctrl_wr_s;
  logic          clear_s;
  logic          we_s;
  logic [14:0]   lane_off_s;
  logic [14:0]   entry_off_s;
  logic          in_range_s;
  logic [31:0]   reg_rdata_s;
  logic [31:0]   lane_data_s;
  logic          unused_s;

  assign in_ready    = 1'b1;
  assign unused_s    = ^{status_addr, status_writedata};
  assign hit_s       = (req_blk_r == BLOCK_ID);
  assign rd_s        = req_read_r & hit_s;
  assign ctrl_wr_s   = req_write_r & hit_s & ~req_addr_r[15] & (req_addr_r[3:0] == 4'd0);
  assign clear_s     = ctrl_wr_s & req_wdata_r[2];
  assign we_s        = s2_valid_r & armed_r & ~clear_s;
  assign lane_off_s  = req_addr_r[14:0] & 15'(LANES - 1);
  assign entry_off_s = req_addr_r[14:0] >> LANE_W;
  assign in_range_s  = ({17'd0, entry_off_s} < 32'(DEPTH));
  assign lane_data_s = mem_q_r[{rsp_lane_r, 5'd0} +: 32];

  // Register-window read mux, sampled before any same-cycle write lands
  always_comb begin
    reg_rdata_s = 32'd0;
    case (req_addr_r[3:0])
      4'd0:    reg_rdata_s = {30'd0, wrap_mode_r, armed_r};
      4'd1:    reg_rdata_s = {29'd0, wrapped_r, full_r, armed_r};
      4'd2:    reg_rdata_s = {{(32-AW){1'b0}}, wr_ptr_r};
      4'd3:    reg_rdata_s = captured_r;
      4'd4:    reg_rdata_s = dropped_r;
      4'd5:    reg_rdata_s = {8'd0, 8'(AW), 16'(DATA_W)};
      default: reg_rdata_s = 32'd0;
    endcase
  end

  // Beat data pipeline; only the valids need a reset value
  always_ff @(posedge clk) begin
    s1_data_r <= in_data;
    s2_data_r <= s1_data_r;
  end

  // Beat valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= in_valid;
      s2_valid_r <= s1_valid_r;
    end
  end

  // Capture memory: write port from stage 2, synchronous read port for the window
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r] <= s2_data_r;
    end
    if (rd_s && req_addr_r[15] && in_range_s) begin
      mem_q_r <= mem_r[entry_off_s[AW-1:0]];
    end
  end

  // Control flags, write pointer and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r     <= ARM_ON_RST;
      wrap_mode_r <= 1'b0;
      full_r      <= 1'b0;
      wrapped_r   <= 1'b0;
      wr_ptr_r    <= '0;
      captured_r  <= 32'd0;
      dropped_r   <= 32'd0;
    end else begin
      if (ctrl_wr_s) begin
        armed_r     <= req_wdata_r[0];
        wrap_mode_r <= req_wdata_r[1];
      end
      if (clear_s) begin
        full_r     <= 1'b0;
        wrapped_r  <= 1'b0;
        wr_ptr_r   <= '0;
        captured_r <= 32'd0;
        dropped_r  <= 32'd0;
      end else if (s2_valid_r && armed_r) begin
        if (captured_r != 32'hFFFF_FFFF) begin
          captured_r <= captured_r + 32'd1;
        end
        if (wr_ptr_r != LAST_PTR) begin
          wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end else if (wrap_mode_r) begin
          wr_ptr_r  <= '0;
          wrapped_r <= 1'b1;
        end else begin
          full_r <= 1'b1;
          // A same-cycle CTRL write owns the armed flag
          if (!ctrl_wr_s) begin
            armed_r <= 1'b0;
          end
        end
      end else if (s2_valid_r) begin
        if (dropped_r != 32'hFFFF_FFFF) begin
          dropped_r <= dropped_r + 32'd1;
        end
      end
    end
  end

  // Status bus: register request, decode, then drive the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_read_r            <= 1'b0;
      req_write_r           <= 1'b0;
      req_blk_r             <= '0;
      req_addr_r            <= 16'd0;
      req_wdata_r           <= 3'd0;
      rsp_valid_r           <= 1'b0;
      rsp_mem_r             <= 1'b0;
      rsp_in_range_r        <= 1'b0;
      rsp_lane_r            <= '0;
      rsp_reg_r             <= 32'd0;
      status_readdata       <= 32'd0;
      status_readdata_valid <= 1'b0;
    end else begin
      req_read_r     <= status_read;
      req_write_r    <= status_write;
      req_blk_r      <= status_addr[29:30-STAT_AWIDTH];
      req_addr_r     <= status_addr[15:0];
      req_wdata_r    <= status_writedata[2:0];
      rsp_valid_r    <= rd_s;
      rsp_mem_r      <= req_addr_r[15];
      rsp_in_range_r <= in_range_s;
      rsp_lane_r     <= lane_off_s[LW-1:0];
      rsp_reg_r      <= reg_rdata_s;
      status_readdata_valid <= rsp_valid_r;
      if (rsp_valid_r) begin
        if (rsp_mem_r) begin
          status_readdata <= rsp_in_range_r ? lane_data_s : 32'd0;
        end else begin
          status_readdata <= rsp_reg_r;
        end
      end else begin
        status_readdata <= status_readdata;
      end
    end
  end

endmodule

// File: tb/tb_ruleid_capture.sv
// Directed self-checking bench for ruleid_capture (DATA_W=512, DEPTH=512).
module tb_ruleid_capture;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [29:0]  status_addr;
  logic         status_read;
  logic         status_write;
  logic [31:0]  status_writedata;
  logic [31:0]  status_readdata;
  logic         status_readdata_valid;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] rsp_d [0:7];
  int          rsp_c [0:7];
  int          n_rsp;

  ruleid_capture dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .status_addr(status_addr), .status_read(status_read), .status_write(status_write),
    .status_writedata(status_writedata), .status_readdata(status_readdata),
    .status_readdata_valid(status_readdata_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] reg_addr(input logic [3:0] off);
    return {4'hC, 10'd0, 1'b0, 11'd0, off};
  endfunction

  function automatic logic [29:0] mem_addr(input int entry, input int lane);
    return {4'hC, 10'd0, 1'b1, 15'(entry * 16 + lane)};
  endfunction

  // Lane l of beat k holds k in the low bits and l in the top byte
  function automatic logic [511:0] beat(input int k);
    logic [511:0] b;
    for (int l = 0; l < 16; l++) b[32*l +: 32] = 32'(k) | (32'(l) << 24);
    return b;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [29:0] a, input logic [31:0] wd);
    @(negedge clk);
    status_addr = a; status_write = 1'b1; status_writedata = wd;
    @(negedge clk);
    status_write = 1'b0;
  endtask

  // One request; d is X and lat 0 if no response arrives within six cycles
  task automatic do_read(input logic [29:0] a, input logic we, input logic [31:0] wd,
                         output logic [31:0] d, output int lat);
    @(negedge clk);
    status_addr = a; status_read = 1'b1; status_write = we; status_writedata = wd;
    @(negedge clk);
    status_read = 1'b0; status_write = 1'b0;
    lat = 0; d = 'x;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (lat == 0 && status_readdata_valid === 1'b1) begin
        lat = i; d = status_readdata;
      end
    end
  endtask

  task automatic push_range(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk); in_data = beat(k); in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    idle(4);
  endtask

  task automatic test_reset;
    logic [31:0] d; int lat;
    tests_run++;
    if (status_readdata !== 32'd0 || status_readdata_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rd=%h v=%b rdy=%b, expected 0/0/1", status_readdata, status_readdata_valid, in_ready);
    end
    do_read(reg_addr(4'd1), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL reset_status: got %h, expected 00000001", d); end
    do_read(reg_addr(4'd0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL reset_ctrl: got %h, expected 00000001", d); end
  endtask

  task automatic test_basic;
    logic [31:0] d; int lat;
    push_range(1, 4);
    do_read(reg_addr(4'd2), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd4 || lat != 2) begin tests_failed++; $display("FAIL basic_wr_ptr: got %h lat %0d, expected 00000004 lat 2", d, lat); end
    do_read(reg_addr(4'd3), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd4) begin tests_failed++; $display("FAIL basic_captured: got %h, expected 00000004", d); end
    do_read(mem_addr(0, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd1 || lat != 2) begin tests_failed++; $display("FAIL basic_win0: got %h lat %0d, expected 00000001 lat 2", d, lat); end
    do_read(mem_addr(1, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd2 || lat != 2) begin tests_failed++; $display("FAIL basic_win16: got %h lat %0d, expected 00000002 lat 2", d, lat); end
    do_read(mem_addr(1, 5), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'h0500_0002) begin tests_failed++; $display("FAIL basic_win_lane5: got %h, expected 05000002", d); end
    do_read(mem_addr(512, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd0 || lat != 2) begin tests_failed++; $display("FAIL basic_win_oor: got %h lat %0d, expected 00000000 lat 2", d, lat); end
    do_read(reg_addr(4'd9), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL basic_unmapped: got %h, expected 00000000", d); end
  endtask

  task automatic test_oneshot;
    logic [31:0] d; int lat;
    do_write(reg_addr(4'd0), 32'h5);
    push_range(1, 515);
    do_read(reg_addr(4'd1), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'h2) begin tests_failed++; $display("FAIL oneshot_status: got %h, expected 00000002", d); end
    do_read(reg_addr(4'd2), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd511) begin tests_failed++; $display("FAIL oneshot_wr_ptr: got %h, expected 000001ff", d); end
    do_read(reg_addr(4'd3), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd512) begin tests_failed++; $display("FAIL oneshot_captured: got %h, expected 00000200", d); end
    do_read(reg_addr(4'd4), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd3) begin tests_failed++; $display("FAIL oneshot_dropped: got %h, expected 00000003", d); end
    do_read(mem_addr(511, 3), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'h0300_0200) begin tests_failed++; $display("FAIL oneshot_last_entry: got %h, expected 03000200", d); end
  endtask

  task automatic test_circular;
    logic [31:0] d; int lat;
    do_write(reg_addr(4'd0), 32'h7);
    push_range(1, 514);
    do_read(reg_addr(4'd1), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'h5) begin tests_failed++; $display("FAIL circ_status: got %h, expected 00000005", d); end
    do_read(reg_addr(4'd2), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd2) begin tests_failed++; $display("FAIL circ_wr_ptr: got %h, expected 00000002", d); end
    do_read(reg_addr(4'd3), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd514) begin tests_failed++; $display("FAIL circ_captured: got %h, expected 00000202", d); end
    do_read(mem_addr(0, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd513) begin tests_failed++; $display("FAIL circ_entry0: got %h, expected 00000201", d); end
    do_read(mem_addr(1, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd514) begin tests_failed++; $display("FAIL circ_entry1: got %h, expected 00000202", d); end
    do_read(mem_addr(2, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd3) begin tests_failed++; $display("FAIL circ_entry2: got %h, expected 00000003", d); end
  endtask

  // Beat presented one cycle ahead of the CTRL write so both land on the same edge
  task automatic test_ctrl_collision;
    logic [31:0] d; int lat;
    @(negedge clk); in_data = beat(32'hDEAD); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    status_addr = reg_addr(4'd0); status_write = 1'b1; status_writedata = 32'h5;
    @(negedge clk); status_write = 1'b0;
    idle(4);
    do_read(reg_addr(4'd3), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL clear_captured: got %h, expected 00000000", d); end
    do_read(reg_addr(4'd4), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL clear_dropped: got %h, expected 00000000", d); end
    do_read(reg_addr(4'd2), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL clear_wr_ptr: got %h, expected 00000000", d); end
    do_read(mem_addr(2, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd3) begin tests_failed++; $display("FAIL clear_not_written: got %h, expected 00000003", d); end
    // Disarm collides with an armed beat: the beat still lands
    @(negedge clk); in_data = beat(32'hBEEF); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    status_addr = reg_addr(4'd0); status_write = 1'b1; status_writedata = 32'h0;
    @(negedge clk); status_write = 1'b0;
    idle(4);
    do_read(reg_addr(4'd3), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd1) begin tests_failed++; $display("FAIL disarm_captured: got %h, expected 00000001", d); end
    do_read(reg_addr(4'd1), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL disarm_status: got %h, expected 00000000", d); end
    do_read(mem_addr(0, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'hBEEF) begin tests_failed++; $display("FAIL disarm_entry0: got %h, expected 0000beef", d); end
  endtask

  task automatic test_read_write_same;
    logic [31:0] d; int lat;
    do_read(reg_addr(4'd0), 1'b1, 32'h1, d, lat);
    tests_run++;
    if (d !== 32'd0 || lat != 2) begin tests_failed++; $display("FAIL rw_prewrite: got %h lat %0d, expected 00000000 lat 2", d, lat); end
    do_read(reg_addr(4'd0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd1) begin tests_failed++; $display("FAIL rw_postwrite: got %h, expected 00000001", d); end
  endtask

  task automatic test_back_to_back;
    n_rsp = 0;
    @(negedge clk);
    fork
      begin
        status_read = 1'b1; status_addr = reg_addr(4'd2);
        @(negedge clk); status_addr = reg_addr(4'd3);
        @(negedge clk); status_addr = reg_addr(4'd5);
        @(negedge clk); status_addr = {4'h3, 10'd0, 1'b0, 11'd0, 4'd4};
        @(negedge clk); status_read = 1'b0;
      end
      begin
        for (int c = 1; c <= 10; c++) begin
          @(posedge clk); #1;
          if (status_readdata_valid === 1'b1 && n_rsp < 8) begin
            rsp_d[n_rsp] = status_readdata; rsp_c[n_rsp] = c; n_rsp++;
          end
        end
      end
    join
    tests_run++;
    if (n_rsp != 3) begin tests_failed++; $display("FAIL b2b_count: got %0d responses, expected 3", n_rsp); end
    if (n_rsp >= 3) begin
      tests_run++;
      if (rsp_c[0] != 3 || rsp_c[1] != 4 || rsp_c[2] != 5) begin
        tests_failed++;
        $display("FAIL b2b_timing: got cycles %0d,%0d,%0d, expected 3,4,5", rsp_c[0], rsp_c[1], rsp_c[2]);
      end
      tests_run++;
      if (rsp_d[0] !== 32'd1 || rsp_d[1] !== 32'd1 || rsp_d[2] !== 32'h0009_0200) begin
        tests_failed++;
        $display("FAIL b2b_data: got %h %h %h, expected 00000001 00000001 00090200", rsp_d[0], rsp_d[1], rsp_d[2]);
      end
    end
  endtask

  task automatic test_midreset;
    logic [31:0] d; int lat;
    do_write(reg_addr(4'd0), 32'h7);
    do_read(reg_addr(4'd5), 1'b0, 32'd0, d, lat);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); in_data = beat(32'h60 + k); in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    #1;
    tests_run++;
    if (status_readdata !== 32'd0 || status_readdata_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got rd=%h v=%b, expected 0/0", status_readdata, status_readdata_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    push_range(32'h71, 32'h72);
    do_read(reg_addr(4'd2), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd2) begin tests_failed++; $display("FAIL midreset_wr_ptr: got %h, expected 00000002", d); end
    do_read(reg_addr(4'd3), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd2) begin tests_failed++; $display("FAIL midreset_captured: got %h, expected 00000002", d); end
    do_read(reg_addr(4'd0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'd1) begin tests_failed++; $display("FAIL midreset_ctrl: got %h, expected 00000001", d); end
    do_read(mem_addr(0, 0), 1'b0, 32'd0, d, lat);
    tests_run++;
    if (d !== 32'h71) begin tests_failed++; $display("FAIL midreset_entry0: got %h, expected 00000071", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0;
    status_addr = 30'd0; status_read = 1'b0; status_write = 1'b0; status_writedata = 32'd0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    test_reset();
    test_basic();
    test_oneshot();
    test_circular();
    test_ctrl_collision();
    test_read_write_same();
    test_back_to_back();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ruleid_capture.md
Name: ruleid_capture

Overview:
Parametrised capture buffer that snoops a wide datapath beat stream (e.g. rule-ID match vectors) into on-chip memory and exposes it, plus control and counters, on the status register bus. Successor to the fixed 512x512 one-shot capture: configurable width and depth, one-shot or circular mode, software arm/clear, and drop/capture counters. Single clock domain; the status bus runs on clk. Sits beside the pipeline stage it observes and never back-pressures it.

Parameters:
DATA_W, 512, captured beat width; multiple of 32; DATA_W/32 a power of two (LANES).
DEPTH, 512, number of stored beats; power of two; DEPTH*LANES <= 32768.
BLOCK_ID, RULEID, status block select compared against status_addr[29:30-STAT_AWIDTH].
ARM_ON_RST, 1, value of the armed flag after reset.

Ports:
clk  in  1  single clock, including the status bus.
rst_n  in  1  reset; asynchronous assert, active-low.
in_data  in  DATA_W  snooped beat.
in_valid  in  1  beat qualifier.
in_ready  out  1  constant 1; never stalls.
status_addr  in  30  [29:30-STAT_AWIDTH] block select; [15] 0=register, 1=memory window; [14:0] offset.
status_read  in  1  read strobe, one cycle per request.
status_write  in  1  write strobe.
status_writedata  in  32  write data.
status_readdata  out  32  read data; holds last value between responses.
status_readdata_valid  out  1  one-cycle pulse per accepted read.

Behaviour:
- Reset (rst_n low, async): armed=ARM_ON_RST, wrap_mode=0, wr_ptr=0, full=0, wrapped=0, captured=0, dropped=0, input pipeline valids=0, status_readdata=0, status_readdata_valid=0. Memory contents undefined.
- Input path: in_data/in_valid registered through 2 stages; a beat is evaluated at stage 2 (write occurs on the 3rd edge after presentation).
- Stage-2 beat rules, priority order: CLEAR applied this cycle -> beat discarded, not counted. Armed -> mem[wr_ptr]=beat, captured++ (saturate at 0xFFFFFFFF). Not armed -> dropped++ (saturating).
- Pointer: increments on every write. At wr_ptr==DEPTH-1: one-shot -> full=1, armed=0, wr_ptr holds DEPTH-1 (all DEPTH entries hold data). Circular -> wr_ptr=0, wrapped=1, armed stays 1.
- Status bus pipeline: strobes, address and writedata registered at edge T; decode and act at edge T+1; read response (status_readdata, valid=1) registered at edge T+2. Requests pipeline back-to-back, one per cycle; responses return in order. A request whose block select != BLOCK_ID is ignored (no response). Simultaneous read and write: both performed, the read returns pre-write data.
- Register map (addr[15]=0, offset addr[3:0]):
  0 CTRL RW: [0] ARM, [1] WRAP_MODE, [2] CLEAR (write-1 pulse, reads 0). CLEAR zeroes wr_ptr, full, wrapped, captured, dropped; ARM/WRAP_MODE take the written value in the same write.
  1 STATUS RO: [0] armed, [1] full, [2] wrapped.
  2 WR_PTR RO, zero-extended.
  3 CAPTURED RO. 4 DROPPED RO.
  5 PARAMS RO: [15:0] DATA_W, [23:16] log2(DEPTH).
  Other offsets read 0; writes ignored.
- Memory window (addr[15]=1): entry = offset >> log2(LANES), lane = offset[log2(LANES)-1:0]; returns bits [32*lane+31:32*lane] of mem[entry]. Entry >= DEPTH returns 0. Synchronous-read memory; a read of the entry written in the same cycle returns old data.
- A CTRL write and a stage-2 beat in the same cycle: the beat uses the armed state before the write.

Test Plan:
- Reset with ARM_ON_RST=1, push 4 beats of 0x..01..04 -> WR_PTR=4, CAPTURED=4; window reads offsets 0 and 16 (LANES=16) return lane0 of beats 1 and 2 with valid exactly 2 cycles after the registered strobe.
- One-shot fill: push DEPTH+3 beats -> STATUS=0b010, WR_PTR=DEPTH-1, CAPTURED=DEPTH, DROPPED=3, entry DEPTH-1 holds beat DEPTH.
- Circular: CTRL=0b011 then DEPTH+2 beats -> STATUS=0b101, WR_PTR=2, entries 0/1 hold beats DEPTH+1/DEPTH+2.
- CLEAR in the same cycle as a stage-2 beat -> beat not written, CAPTURED=0, DROPPED=0, WR_PTR=0.
- Back-to-back reads of offsets 2,3,5 plus one read with foreign block select -> exactly three in-order responses on consecutive cycles; PARAMS=0x0009_0200.
- Assert rst_n mid-stream for 1 cycle -> all outputs/counters return to reset values immediately; capture resumes at WR_PTR=0.
